beep_scheduler: RTL and testbench
=================================

# beep_scheduler

Shares the single board buzzer between several requesters. Each requester asks for a burst of N tone beeps at its own pitch; the block arbitrates by fixed priority and sequences each burst as timed tone-on / silence windows. It drives the `beep` pin directly, replacing ad-hoc switch-gated tone generators. It sits between system status logic (alarms, key clicks, error codes) and the buzzer pad.

## Interface
- `N_REQ`, 3: number of requesters; index 0 is highest priority.
- `HP_W`, 16: width of each tone half-period field, in clocks.
- `CNT_W`, 4: width of each beep-count field.
- `ON_CYCLES`, 2_500_000: tone-on window per beep, in clocks (100 ms). Must be ≥1.
- `OFF_CYCLES`, 1_250_000: silence after each beep, in clocks (50 ms). Must be ≥1.

- `ext_clk_25m`  in  1  system clock, 25 MHz.
- `ext_rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester level request; held until its `ack`.
- `half_period`  in  N_REQ*HP_W  packed; slice i = tone half-period for requester i.
- `beep_count`  in  N_REQ*CNT_W  packed; slice i = beeps in burst for requester i.
- `mute`  in  1  active-high; forces `beep` low, sequencing unaffected.
- `grant`  out  N_REQ  one-hot, held for the whole service of the granted requester.
- `ack`  out  N_REQ  one-cycle completion pulse to the served requester.
- `busy`  out  1  high from grant through DONE.
- `beep`  out  1  registered buzzer drive.

## Operation
- States: IDLE, TONE_ON, TONE_OFF, DONE.
- IDLE: if any `req` is high, select the lowest index, register its `half_period` and `beep_count` slices, set `grant` and `busy`. Go to TONE_ON, or to DONE if the latched count is 0.
- TONE_ON: runs for ON_CYCLES clocks. `beep` is 1 in the first cycle. The tone counter counts 0..hp-1, and `beep` toggles on each wrap, giving a square wave with period 2·hp clocks. A latched hp of 0 is treated as 1. Then go to TONE_OFF.
- TONE_OFF: runs for OFF_CYCLES clocks with `beep`=0. Then decrement the remaining count. If the result is 0, go to DONE; otherwise go to TONE_ON and restart the tone counter with `beep`=1.
- DONE: lasts exactly one cycle. `ack[i]` is 1 and `grant[i]` is still 1. Next state is IDLE, where `grant` and `busy` are 0 for at least one cycle.
- There is no preemption. Requests arriving during service wait. Inputs are latched at grant, so later changes to the slices are ignored.
- A `req` still high in the IDLE cycle after `ack` is treated as a new request and re-granted. Requesters drop `req` on the cycle they see `ack`.
- `req` dropped before `ack` does not abort the burst.
- `beep` = tone bit AND NOT `mute`, registered.
- Window counters are ≥24 bits. Beep counter is CNT_W bits. No overflow is possible at the parameter limits.

## Timing
- Reset, asynchronous: state IDLE, all counters 0, and `beep`, `grant`, `ack`, `busy` all 0 immediately, including mid-burst. After release, held requests are re-arbitrated from IDLE; the interrupted burst is not resumed.
- `req` high at IDLE edge k: `grant` and `busy` are high after edge k+1, and the first TONE_ON cycle is k+1.
- Burst of n beeps: TONE_ON/TONE_OFF occupy n·(ON_CYCLES+OFF_CYCLES) cycles. `ack` follows in the next cycle (DONE). The earliest next grant is 2 cycles after `ack`: the IDLE cycle, then grant.
- Count 0: DONE at k+1, and `ack` coincides with the first `grant` cycle. `beep` stays 0.
- Simultaneous requests resolve strictly by index in the same IDLE cycle.
- `mute` takes effect on `beep` one clock after it changes. It does not affect `ack` timing.

## Test plan
- Test parameters: ON_CYCLES=20, OFF_CYCLES=10.
- Single burst: req0, hp=3, count=2, raised at edge 0 → `grant`=001 from cycle 1; `beep` toggles every 3 cycles during cycles 1–20 and 31–50 and is 0 during cycles 21–30 and 51–60; `ack[0]` pulses at cycle 61; `busy` falls at cycle 62.
- Contention: req0 and req2 raised together, each count=1 → req0 served first; `ack[0]` at 31; `grant`=100 at cycle 33; `ack[2]` at 63.
- No preemption: req2 is being served and req0 rises mid-TONE_ON → `grant` stays 100 until `ack[2]`; req0 is granted 2 cycles later.
- Count 0: req1 with count=0 → `grant[1]` and `ack[1]` both high at cycle 1; `beep` is never 1; `busy` is low at cycle 2.
- Mute: assert `mute` during the 2nd beep → `beep` is 0 from the next cycle; `ack` still arrives at cycle 61.
- Reset mid-burst: assert `ext_rst_n`=0 at cycle 15 of a burst → all outputs 0 asynchronously; with req0 still high at release, `grant` returns 1 cycle after the first post-reset edge, and the burst restarts from beep 1.

Source files
------------

// File: rtl/beep_scheduler.sv
// beep_scheduler: fixed-priority arbiter that shares one buzzer among N_REQ
// requesters. It plays each granted burst as timed tone-on / silence windows.
module beep_scheduler #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned HP_W       = 16,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned ON_CYCLES  = 2_500_000,
    parameter int unsigned OFF_CYCLES = 1_250_000
) (
    input  logic                     ext_clk_25m,
    input  logic                     ext_rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*HP_W-1:0]    half_period,
    input  logic [N_REQ*CNT_W-1:0]   beep_count,
    input  logic                     mute,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic                     beep
);

    localparam int unsigned WIN_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned WIN_W   = ($clog2(WIN_MAX) > 24) ? $clog2(WIN_MAX) : 24;

    localparam logic [WIN_W-1:0] ON_LAST  = WIN_W'(ON_CYCLES - 1);
    localparam logic [WIN_W-1:0] OFF_LAST = WIN_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TONE_ON,
        S_TONE_OFF,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIN_W-1:0]   win_cnt;
    logic [HP_W-1:0]    tone_cnt;
    logic [HP_W-1:0]    hp_lat;
    logic [CNT_W-1:0]   rem_cnt;
    logic               tone;

    logic [N_REQ-1:0]   sel_onehot;
    logic               sel_valid;
    logic [HP_W-1:0]    sel_hp;
    logic [CNT_W-1:0]   sel_cnt;

    // Lowest-index active request wins; also pick its parameter slices
    always_comb begin
        sel_onehot = '0;
        sel_valid  = 1'b0;
        sel_hp     = '0;
        sel_cnt    = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_valid     = 1'b1;
                sel_hp        = half_period[i*HP_W +: HP_W];
                sel_cnt       = beep_count[i*CNT_W +: CNT_W];
            end
        end
    end

    // Burst sequencer: arbitration, window timing, tone generation and outputs
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state    <= S_IDLE;
            win_cnt  <= '0;
            tone_cnt <= '0;
            hp_lat   <= '0;
            rem_cnt  <= '0;
            tone     <= 1'b0;
            grant    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            beep     <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    beep  <= 1'b0;
                    tone  <= 1'b0;
                    if (sel_valid) begin
                        grant    <= sel_onehot;
                        busy     <= 1'b1;
                        hp_lat   <= (sel_hp == '0) ? HP_W'(1) : sel_hp;
                        win_cnt  <= '0;
                        tone_cnt <= '0;
                        if (sel_cnt == '0) begin
                            // Empty burst: complete immediately, buzzer stays silent
                            state   <= S_DONE;
                            rem_cnt <= '0;
                            ack     <= sel_onehot;
                        end else begin
                            state   <= S_TONE_ON;
                            rem_cnt <= sel_cnt;
                            tone    <= 1'b1;
                            beep    <= ~mute;
                        end
                    end
                end

                S_TONE_ON: begin
                    if (win_cnt == ON_LAST) begin
                        state    <= S_TONE_OFF;
                        win_cnt  <= '0;
                        tone_cnt <= '0;
                        tone     <= 1'b0;
                        beep     <= 1'b0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        if (tone_cnt == hp_lat - HP_W'(1)) begin
                            tone_cnt <= '0;
                            tone     <= ~tone;
                            beep     <= ~tone & ~mute;
                        end else begin
                            tone_cnt <= tone_cnt + HP_W'(1);
                            beep     <= tone & ~mute;
                        end
                    end
                end

                S_TONE_OFF: begin
                    beep <= 1'b0;
                    if (win_cnt == OFF_LAST) begin
                        win_cnt <= '0;
                        if (rem_cnt == CNT_W'(1)) begin
                            state   <= S_DONE;
                            rem_cnt <= '0;
                            ack     <= grant;
                        end else begin
                            state    <= S_TONE_ON;
                            rem_cnt  <= rem_cnt - CNT_W'(1);
                            tone_cnt <= '0;
                            tone     <= 1'b1;
                            beep     <= ~mute;
                        end
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    beep  <= 1'b0;
                    tone  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: directed bench for beep_scheduler with short windows.
module tb_beep_scheduler;

    localparam int unsigned N_REQ = 3;
    localparam int unsigned HP_W  = 16;
    localparam int unsigned CNT_W = 4;
    localparam int          ON    = 20;
    localparam int          OFF   = 10;

    logic                   ext_clk_25m = 1'b0;
    logic                   ext_rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*HP_W-1:0]  half_period;
    logic [N_REQ*CNT_W-1:0] beep_count;
    logic                   mute;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic                   busy;
    logic                   beep;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected service schedule: requester, first grant cycle, count, half-period
    int svc_idx   [4];
    int svc_start [4];
    int svc_n     [4];
    int svc_hp    [4];
    int n_svc;

    beep_scheduler #(
        .N_REQ      (N_REQ),
        .HP_W       (HP_W),
        .CNT_W      (CNT_W),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .ext_clk_25m (ext_clk_25m),
        .ext_rst_n   (ext_rst_n),
        .req         (req),
        .half_period (half_period),
        .beep_count  (beep_count),
        .mute        (mute),
        .grant       (grant),
        .ack         (ack),
        .busy        (busy),
        .beep        (beep)
    );

    always #20 ext_clk_25m = ~ext_clk_25m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_slot(input int idx, input int hp, input int cnt);
        half_period[idx*HP_W +: HP_W] = HP_W'(hp);
        beep_count[idx*CNT_W +: CNT_W] = CNT_W'(cnt);
    endtask

    task automatic add_svc(input int idx, input int start, input int n, input int hp);
        svc_idx[n_svc]   = idx;
        svc_start[n_svc] = start;
        svc_n[n_svc]     = n;
        svc_hp[n_svc]    = hp;
        n_svc++;
    endtask

    // Expected outputs in cycle c (cycle c follows clock edge c after the start edge)
    function automatic void model(input int c, input int m_on, input int m_off,
                                  output logic [2:0] g, output logic [2:0] a,
                                  output logic b, output logic bp);
        int s, d, o, h;
        g = '0; a = '0; b = 1'b0; bp = 1'b0;
        for (int k = 0; k < n_svc; k++) begin
            s = svc_start[k];
            d = s + svc_n[k] * (ON + OFF);
            if (c >= s && c <= d) begin
                g[svc_idx[k]] = 1'b1;
                b = 1'b1;
                if (c == d) begin
                    a[svc_idx[k]] = 1'b1;
                end else begin
                    o = (c - s) % (ON + OFF);
                    h = (svc_hp[k] == 0) ? 1 : svc_hp[k];
                    if (o < ON) bp = ((o / h) % 2) == 0;
                end
            end
        end
        if (c > m_on && c <= m_off) bp = 1'b0;
    endfunction

    // Step ncyc cycles from the start edge, checking every output each cycle
    task automatic run(input string name, input int ncyc, input int raise_at,
                       input logic [2:0] raise_mask, input int m_on, input int m_off);
        logic [2:0] eg, ea;
        logic       eb, ebp;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge ext_clk_25m);
            @(negedge ext_clk_25m);
            model(c, m_on, m_off, eg, ea, eb, ebp);
            check($sformatf("%s grant c%0d", name, c), 32'(grant), 32'(eg));
            check($sformatf("%s ack c%0d",   name, c), 32'(ack),   32'(ea));
            check($sformatf("%s busy c%0d",  name, c), 32'(busy),  32'(eb));
            check($sformatf("%s beep c%0d",  name, c), 32'(beep),  32'(ebp));
            for (int i = 0; i < int'(N_REQ); i++) if (ack[i]) req[i] = 1'b0;
            if (c == raise_at) req = req | raise_mask;
            if (c == m_on)  mute = 1'b1;
            if (c == m_off) mute = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string name);
        check($sformatf("%s grant", name), 32'(grant), 32'd0);
        check($sformatf("%s ack",   name), 32'(ack),   32'd0);
        check($sformatf("%s busy",  name), 32'(busy),  32'd0);
        check($sformatf("%s beep",  name), 32'(beep),  32'd0);
    endtask

    initial begin
        ext_rst_n   = 1'b0;
        req         = '0;
        mute        = 1'b0;
        half_period = '0;
        beep_count  = '0;
        #50;
        check_all_zero("reset");
        @(posedge ext_clk_25m);
        #1 ext_rst_n = 1'b1;
        repeat (2) @(posedge ext_clk_25m);

        // Single burst: hp=3, two beeps
        @(posedge ext_clk_25m);
        #1;
        set_slot(0, 3, 2);
        req   = 3'b001;
        n_svc = 0;
        add_svc(0, 1, 2, 3);
        run("single", 64, 0, 3'b000, 0, 0);

        // Contention: req0 and req2 together, req2 with hp=0 (treated as 1)
        @(posedge ext_clk_25m);
        #1;
        set_slot(0, 2, 1);
        set_slot(2, 0, 1);
        req   = 3'b101;
        n_svc = 0;
        add_svc(0, 1, 1, 2);
        add_svc(2, 33, 1, 0);
        run("contend", 65, 0, 3'b000, 0, 0);

        // No preemption: req0 rises while req2 is in TONE_ON
        @(posedge ext_clk_25m);
        #1;
        set_slot(2, 4, 1);
        set_slot(0, 3, 1);
        req   = 3'b100;
        n_svc = 0;
        add_svc(2, 1, 1, 4);
        add_svc(0, 33, 1, 3);
        run("nopreempt", 64, 10, 3'b001, 0, 0);

        // Zero-length burst on req1
        @(posedge ext_clk_25m);
        #1;
        set_slot(1, 5, 0);
        req   = 3'b010;
        n_svc = 0;
        add_svc(1, 1, 0, 5);
        run("count0", 3, 0, 3'b000, 0, 0);

        // Mute across part of the second beep
        @(posedge ext_clk_25m);
        #1;
        set_slot(0, 3, 2);
        req   = 3'b001;
        n_svc = 0;
        add_svc(0, 1, 2, 3);
        run("mute", 64, 0, 3'b000, 35, 45);

        // Reset during cycle 15 of a burst, req0 held through reset
        @(posedge ext_clk_25m);
        #1;
        set_slot(0, 3, 1);
        req   = 3'b001;
        n_svc = 0;
        add_svc(0, 1, 1, 3);
        run("prerst", 15, 0, 3'b000, 0, 0);
        #5 ext_rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge ext_clk_25m);
        @(negedge ext_clk_25m);
        check_all_zero("rst_held");
        @(posedge ext_clk_25m);
        #1 ext_rst_n = 1'b1;
        run("postrst", 32, 0, 3'b000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
